// File: rtl/mem_arbiter_if.sv
// Bundles the I-cache, D-cache and shared memory line-port signals of the arbiter.
// The slave modport is the arbiter's view; the master modport is the caches/memory side.
interface mem_arbiter_if #(
    parameter int LINE_BITS = 256,
    parameter int ADDR_BITS = 32
);
    logic                 i_read;
    logic [ADDR_BITS-1:0] i_addr;
    logic [LINE_BITS-1:0] i_rdata;
    logic                 i_resp;

    logic                 d_read;
    logic                 d_write;
    logic [ADDR_BITS-1:0] d_addr;
    logic [LINE_BITS-1:0] d_wdata;
    logic [LINE_BITS-1:0] d_rdata;
    logic                 d_resp;

    logic                 mem_read;
    logic                 mem_write;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [LINE_BITS-1:0] mem_wdata;
    logic [LINE_BITS-1:0] mem_rdata;
    logic                 mem_resp;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory line port between I-cache and D-cache.
// Latency: grant -> mem_* next cycle; mem_resp at k -> x_resp pulse at k+1, IDLE at k+2.
// Backpressure: requesters hold until x_resp; one memory transaction outstanding at a time.
module mem_arbiter #(
    parameter int LINE_BITS = 256,
    parameter int ADDR_BITS = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        DONE_I,
        DONE_D
    } state_t;

    state_t               state;
    logic                 last;
    logic                 op_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [LINE_BITS-1:0] wdata_q;
    logic [LINE_BITS-1:0] i_rdata_q;
    logic [LINE_BITS-1:0] d_rdata_q;
    logic                 mem_read_q;
    logic                 mem_write_q;
    logic                 i_resp_q;
    logic                 d_resp_q;

    logic i_pend;
    logic d_pend;
    logic grant_d;

    assign i_pend  = bus.i_read;
    assign d_pend  = bus.d_read | bus.d_write;
    // On a tie the requester that was not served last wins.
    assign grant_d = d_pend & (~i_pend | ~last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last        <= 1'b1;
            op_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            i_resp_q    <= 1'b0;
            d_resp_q    <= 1'b0;
        end else begin
            i_resp_q <= 1'b0;
            d_resp_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state       <= SERVE_D;
                        addr_q      <= bus.d_addr;
                        op_q        <= bus.d_write;
                        mem_write_q <= bus.d_write;
                        mem_read_q  <= ~bus.d_write;
                        if (bus.d_write) begin
                            wdata_q <= bus.d_wdata;
                        end
                    end else if (i_pend) begin
                        state       <= SERVE_I;
                        addr_q      <= bus.i_addr;
                        op_q        <= 1'b0;
                        mem_read_q  <= 1'b1;
                        mem_write_q <= 1'b0;
                    end
                end
                SERVE_I: begin
                    if (bus.mem_resp) begin
                        state      <= DONE_I;
                        last       <= 1'b0;
                        mem_read_q <= 1'b0;
                        i_resp_q   <= 1'b1;
                        i_rdata_q  <= bus.mem_rdata;
                    end
                end
                SERVE_D: begin
                    if (bus.mem_resp) begin
                        state       <= DONE_D;
                        last        <= 1'b1;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        d_resp_q    <= 1'b1;
                        // A writeback leaves the previously returned line visible.
                        if (!op_q) begin
                            d_rdata_q <= bus.mem_rdata;
                        end
                    end
                end
                DONE_I, DONE_D: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_resp    = i_resp_q;
    assign bus.d_resp    = d_resp_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

    // Simultaneous read and write from the D-cache is illegal; it is serviced as a write.
    illegal_d_rw: assert property (@(posedge clk) disable iff (rst) !(bus.d_read && bus.d_write));

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one shared physical-memory line port between the instruction cache and data cache that sit behind the pipelined datapath's `inst_*` and `data_*` ports. Each cache issues a full-line miss fill (read) or writeback (write, D-cache only) and holds the request until it receives a response. The arbiter grants one requester at a time and latches that requester's address and write data. It runs the transaction on the memory port and returns one registered response pulse. Simultaneous requests are resolved round-robin, so neither cache can starve the other.

## Interface
- `LINE_BITS`, 256, cache-line width in bits (width of all data buses)
- `ADDR_BITS`, 32, address width
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_read`  in  1  I-cache line read request, held until `i_resp`
- `i_addr`  in  ADDR_BITS  I-cache line address (low 5 bits zero)
- `i_rdata`  out  LINE_BITS  line returned to I-cache, valid while `i_resp`=1
- `i_resp`  out  1  one-cycle completion pulse to I-cache
- `d_read`  in  1  D-cache line read request, held until `d_resp`
- `d_write`  in  1  D-cache line writeback request, held until `d_resp`
- `d_addr`  in  ADDR_BITS  D-cache line address
- `d_wdata`  in  LINE_BITS  writeback line
- `d_rdata`  out  LINE_BITS  line returned to D-cache, valid while `d_resp`=1
- `d_resp`  out  1  one-cycle completion pulse to D-cache
- `mem_read`  out  1  memory line read, held until `mem_resp`
- `mem_write`  out  1  memory line write, held until `mem_resp`
- `mem_addr`  out  ADDR_BITS  latched address of the granted transaction
- `mem_wdata`  out  LINE_BITS  latched writeback data
- `mem_rdata`  in  LINE_BITS  read data, valid while `mem_resp`=1
- `mem_resp`  in  1  memory completion

## Operation
- States:
  - IDLE
  - SERVE_I
  - SERVE_D
  - DONE_I
  - DONE_D
- `last` register records the last-served requester: 0=I, 1=D.
- IDLE transitions:
  - `i_read` only → SERVE_I.
  - `d_read` or `d_write` only → SERVE_D.
  - Both requesters pending → grant the one NOT equal to `last`.
  - On grant, latch the address and op into `addr_q`/`op_q`; for a D write also latch `d_wdata` into `wdata_q`.
- SERVE_x:
  - `mem_read`/`mem_write` are driven from the latched op.
  - `mem_addr`=`addr_q`, `mem_wdata`=`wdata_q`.
  - Stay in SERVE_x until `mem_resp`=1. Then capture `mem_rdata` into `rdata_q`, set `last`=x, and go to DONE_x.
- DONE_x:
  - `x_resp`=1 for exactly this cycle; `x_rdata`=`rdata_q`.
  - `mem_read`=`mem_write`=0.
  - All requests are ignored this cycle.
  - Next state is IDLE unconditionally.
- Requester rule: drop the request on the edge after seeing `x_resp`. By the time the arbiter is back in IDLE the old request is gone.
- Address/data changes on inputs during SERVE_x are ignored (latched values rule).
- `d_read` and `d_write` both high is illegal. Treat it as a write, and a simulation assertion fires.
- On a write transaction, `d_rdata` holds its previous value. `d_resp` still pulses.
- Unselected `x_rdata` holds its previous value; data is meaningful only with `x_resp`.
- No address-range checks and no reordering; exactly one outstanding memory transaction.

## Timing
- Reset (synchronous, `rst`=1 at edge):
  - state=IDLE, `last`=1 (so the I-cache wins the first simultaneous request).
  - `addr_q`, `wdata_q`, `rdata_q` = 0.
  - All outputs 0: `mem_read`, `mem_write`, `mem_addr`, `mem_wdata`, `i_resp`, `d_resp`, `i_rdata`, `d_rdata`.
- Reset mid-transaction (SERVE or DONE): everything returns to IDLE/reset values at that edge, and no `x_resp` is issued. Memory is also reset by the same `rst`.
- Latency: request seen in IDLE at cycle 0 → `mem_*` asserted cycle 1. `mem_resp` at cycle k≥1 → `x_resp` at cycle k+1 → IDLE at k+2.
  - Minimum request-to-response is 2 cycles.
  - Back-to-back gap is 1 IDLE cycle between grants.
- Outputs `mem_*`, `x_resp` and `x_rdata` are pure functions of registered state (no combinational input-to-output paths).
- `mem_resp` outside SERVE states is ignored.
- Request raised during DONE of the other requester: it is sampled in the following IDLE cycle and wins if it is not `last`.

## Test plan
- Reset then I-only read at `0x0000_0060`:
  - `mem_read`=1, `mem_addr`=`0x60` in cycle 1.
  - Memory resp in cycle 3 with data `0xA5..A5`.
  - `i_resp`=1 in cycle 4 with `i_rdata`=`0xA5..A5`; `d_resp` stays 0.
- Simultaneous `i_read`@`0x100` and `d_read`@`0x200` right after reset:
  - I served first (`last`=1 at reset), then D.
  - Issue order on `mem_addr` is `0x100`, `0x200`; each `resp` fires once.
- D writeback `d_wdata`=`0xDEAD_BEEF` repeated to `0x400`:
  - `mem_write`=1, `mem_wdata` matches.
  - Input data is changed mid-transaction; `mem_wdata` stays latched.
  - `d_resp` pulses one cycle; `d_rdata` is unchanged.
- Starvation check: both caches re-request continuously for 20 transactions → grants strictly alternate I, D, I, D…
- Assert `rst` while in SERVE_D with `mem_write`=1 → next cycle all outputs 0, state IDLE, no `d_resp`. A subsequent I read completes normally.
- `mem_resp` pulsed during IDLE and during DONE_I → no state change, no spurious `resp`.
